mbus_rx_msg_buffer: RTL
=======================

# mbus_rx_msg_buffer

Receive-side message assembler for the MBus controller's RX handshake interface (RX_ADDR/RX_DATA/RX_REQ/RX_PEND/RX_FAIL/RX_BROADCAST/RX_ACK). It is the consumer that pairs with the controller-side TX transaction sequencing used in the layer-controller system bench. It acks each received word, frames multi-word messages, and discards failed or overflowing messages atomically. Only complete messages are presented to a local ready/valid read port, together with a per-message header (address, broadcast flag, length).

## Interface
Parameters:
- DEPTH, 16, data FIFO words; power of 2, ≥4
- HDR_DEPTH, 4, header FIFO entries (committed messages); power of 2
- AW = log2(DEPTH); LW = AW+1 (derived, not overridable)

Ports (one clock; reset is synchronous and active-high):
- CLK  in  1  sole clock; all logic on posedge
- RESET  in  1  synchronous, active-high reset
- RX_ADDR  in  32  message address (valid with RX_REQ)
- RX_DATA  in  32  word payload
- RX_REQ  in  1  word available (4-phase with RX_ACK)
- RX_PEND  in  1  1 = more words follow in this message
- RX_FAIL  in  1  current message aborted (4-phase with RX_ACK)
- RX_BROADCAST  in  1  message is broadcast
- RX_ACK  out  1  handshake ack to controller
- MSG_DATA  out  32  head word of committed data
- MSG_VALID  out  1  MSG_DATA valid
- MSG_READY  in  1  consumer pops word when MSG_VALID & MSG_READY
- MSG_LAST  out  1  head word is last of its message
- MSG_ADDR  out  32  head message address
- MSG_BCAST  out  1  head message broadcast flag
- MSG_LEN  out  LW  head message word count (1..DEPTH)
- DROP_CNT  out  8  saturating count of discarded messages
- OVERFLOW  out  1  sticky; set on any overflow discard

## Operation
- Storage: data FIFO entries {last, data}; pointers wr_ptr, commit_ptr, rd_ptr (AW+1 bits, wrap mod 2·DEPTH). Header FIFO {addr, bcast, len}.
- Per-message registers: cur_len (LW), cur_addr, cur_bcast, first (1 = next word starts a message), discard.
- FSM states:
  - IDLE: if RX_FAIL → FAIL_ACK, else if RX_REQ → capture, → WORD_ACK.
  - WORD_ACK: RX_ACK=1; when RX_REQ=0 → IDLE.
  - FAIL_ACK: RX_ACK=1; when RX_FAIL=0 → IDLE.
- RX_FAIL has priority over RX_REQ when both are high in IDLE.
- Capture, on the IDLE→WORD_ACK edge:
  - If first: latch RX_ADDR/RX_BROADCAST, cur_len=0, discard=0.
  - If discard=0 and data FIFO has free slot beyond wr_ptr: write {~RX_PEND, RX_DATA}, wr_ptr+1, cur_len+1. Otherwise discard=1 and nothing is written.
  - If RX_PEND=0 (message end):
    - If discard=0 and header FIFO not full: push header (len = cur_len+1), commit_ptr=wr_ptr+1.
    - Else: wr_ptr=commit_ptr (rollback), DROP_CNT+1 (saturate 255), OVERFLOW=1.
    - first=1.
  - If RX_PEND=1: first=0.
- FAIL entry: wr_ptr=commit_ptr, first=1, discard=0, DROP_CNT+1 (saturating); OVERFLOW unchanged. A FAIL while first=1 (no partial words) still counts.
- Full test uses wr_ptr−rd_ptr against DEPTH at the capture edge, before any same-cycle pop. Conservative; a word is never lost to an in-cycle race.
- Read side:
  - MSG_VALID = (commit_ptr≠rd_ptr).
  - MSG_DATA/MSG_LAST come from rd_ptr; MSG_ADDR/BCAST/LEN come from the header head.
  - Pop advances rd_ptr. Popping a word with last=1 also pops the header.

## Timing
- Reset values: RX_ACK=0, MSG_VALID=0, MSG_LAST=0, MSG_DATA=0, MSG_ADDR=0, MSG_BCAST=0, MSG_LEN=0, DROP_CNT=0, OVERFLOW=0. All pointers 0, first=1, FSM IDLE.
- RX_ACK rises 1 cycle after RX_REQ/RX_FAIL is sampled high. It falls 1 cycle after the request is sampled low. Next request is accepted no earlier than the cycle after RX_ACK=0.
- Committed message: MSG_VALID rises the cycle after the final word's capture edge (1-cycle latency). MSG_* outputs are registered/array reads stable while MSG_VALID & ~MSG_READY.
- Simultaneous commit and pop: both take effect; MSG_VALID stays high if words remain.
- RESET mid-message or mid-handshake drops all buffered and partial data and forces RX_ACK=0 next cycle. An RX_REQ still high afterward is treated as the first word of a new message.
- Message longer than DEPTH always overflows and is discarded whole. Handshakes continue normally so the bus is never stalled.

## Test plan
- Single-word message, ADDR=0x000000A5, DATA=0xDEADBEEF, PEND=0:
  - RX_ACK high 1 cycle after REQ, low 1 cycle after REQ drops.
  - MSG_VALID next cycle with LEN=1, LAST=1, BCAST=0.
  - Pop → MSG_VALID=0.
- 3-word message 0x11,0x22,0x33 (PEND 1,1,0), MSG_READY held 0:
  - MSG_VALID stays 0 until the 3rd capture.
  - Then LEN=3; pops return 0x11,0x22,0x33 with LAST only on 0x33.
- 2 words then RX_FAIL:
  - RX_ACK handshakes the fail; MSG_VALID never rises; DROP_CNT=1; OVERFLOW=0.
  - Following 1-word message 0x44 is read correctly.
- DEPTH=16, 17-word message, no pops:
  - All 17 words acked; nothing presented; DROP_CNT=1, OVERFLOW=1.
  - wr_ptr is restored; a following 16-word message commits with LEN=16.
- Header full: 5 one-word messages, HDR_DEPTH=4, no pops:
  - First 4 commit; 5th is dropped (DROP_CNT=1, OVERFLOW=1).
  - Pop all; 4 headers read in order.
- RESET asserted during WORD_ACK of word 2 of 3:
  - RX_ACK=0 and all outputs at reset values next cycle.
  - Subsequent 1-word message 0x55 is read with LEN=1.

Source files
------------

// File: rtl/mbus_rx_msg_buffer.sv
// Assembles MBus RX words into whole messages; RX_ACK follows REQ/FAIL by 1 cycle, MSG_VALID rises 1 cycle after the final word.
// Never stalls the bus: words that do not fit are acked and the message is dropped; MSG_READY low holds the head word.
module mbus_rx_msg_buffer #(
  parameter int DEPTH     = 16,
  parameter int HDR_DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [31:0]   RX_ADDR,
  input  logic [31:0]   RX_DATA,
  input  logic          RX_REQ,
  input  logic          RX_PEND,
  input  logic          RX_FAIL,
  input  logic          RX_BROADCAST,
  output logic          RX_ACK,
  output logic [31:0]   MSG_DATA,
  output logic          MSG_VALID,
  input  logic          MSG_READY,
  output logic          MSG_LAST,
  output logic [31:0]   MSG_ADDR,
  output logic          MSG_BCAST,
  output logic [LW-1:0] MSG_LEN,
  output logic [7:0]    DROP_CNT,
  output logic          OVERFLOW
);

  localparam int HAW = (HDR_DEPTH > 1) ? $clog2(HDR_DEPTH) : 1;
  localparam logic [AW:0]  DEPTH_L = LW'(DEPTH);
  localparam logic [HAW:0] HDR_L   = (HAW + 1)'(HDR_DEPTH);

  typedef enum logic [1:0] {IDLE, WORD_ACK, FAIL_ACK} state_t;

  typedef struct packed {
    logic [31:0]   addr;
    logic          bcast;
    logic [LW-1:0] len;
  } hdr_t;

  state_t state, state_nxt;
  logic   cap, fail_start;

  logic [32:0] dmem [DEPTH];
  hdr_t        hmem [2**HAW];

  logic [AW:0]   wr_ptr, commit_ptr, rd_ptr;
  logic [HAW:0]  hwr_ptr, hrd_ptr;
  logic [LW-1:0] cur_len;
  logic [31:0]   cur_addr;
  logic          cur_bcast;
  logic          first;
  logic          discard;

  logic [AW:0]   used;
  logic          data_free, hdr_full;
  logic [LW-1:0] len_base, len_new;
  logic          disc_base, disc_now;
  logic          do_write, msg_end, do_commit, do_rollback, do_drop;
  logic [31:0]   hdr_addr;
  logic          hdr_bcast;
  logic [32:0]   head_word;
  hdr_t          head_hdr;
  logic          pop, hdr_pop;

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  // FAIL outranks REQ when both are seen in IDLE
  always_comb begin
    state_nxt  = state;
    cap        = 1'b0;
    fail_start = 1'b0;
    case (state)
      IDLE: begin
        if (RX_FAIL) begin
          state_nxt  = FAIL_ACK;
          fail_start = 1'b1;
        end else if (RX_REQ) begin
          state_nxt = WORD_ACK;
          cap       = 1'b1;
        end
      end
      WORD_ACK: if (!RX_REQ)  state_nxt = IDLE;
      FAIL_ACK: if (!RX_FAIL) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  assign RX_ACK = (state == WORD_ACK) || (state == FAIL_ACK);

  // Occupancy is judged before any same-cycle pop, so a word is never raced out
  assign used      = wr_ptr - rd_ptr;
  assign data_free = (used != DEPTH_L);
  assign hdr_full  = ((hwr_ptr - hrd_ptr) == HDR_L);

  assign len_base  = first ? '0 : cur_len;
  assign disc_base = first ? 1'b0 : discard;
  assign len_new   = len_base + LW'(1);
  assign disc_now  = disc_base || !data_free;

  assign do_write    = cap && !disc_base && data_free;
  assign msg_end     = cap && !RX_PEND;
  assign do_commit   = msg_end && !disc_now && !hdr_full;
  assign do_rollback = msg_end && !do_commit;
  assign do_drop     = do_rollback || fail_start;

  assign hdr_addr  = first ? RX_ADDR : cur_addr;
  assign hdr_bcast = first ? RX_BROADCAST : cur_bcast;

  assign head_word = dmem[rd_ptr[AW-1:0]];
  assign head_hdr  = hmem[hrd_ptr[HAW-1:0]];
  assign MSG_VALID = (commit_ptr != rd_ptr);
  assign pop       = MSG_VALID && MSG_READY;
  assign hdr_pop   = pop && head_word[32];

  // Storage arrays carry no reset; outputs are masked while nothing is committed
  assign MSG_DATA  = MSG_VALID ? head_word[31:0] : '0;
  assign MSG_LAST  = MSG_VALID ? head_word[32]   : 1'b0;
  assign MSG_ADDR  = MSG_VALID ? head_hdr.addr   : '0;
  assign MSG_BCAST = MSG_VALID ? head_hdr.bcast  : 1'b0;
  assign MSG_LEN   = MSG_VALID ? head_hdr.len    : '0;

  always_ff @(posedge CLK) begin
    if (!RESET && do_write)  dmem[wr_ptr[AW-1:0]] <= {~RX_PEND, RX_DATA};
    if (!RESET && do_commit) hmem[hwr_ptr[HAW-1:0]] <= '{addr: hdr_addr, bcast: hdr_bcast, len: len_new};
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      hwr_ptr    <= '0;
      hrd_ptr    <= '0;
      cur_len    <= '0;
      cur_addr   <= '0;
      cur_bcast  <= 1'b0;
      first      <= 1'b1;
      discard    <= 1'b0;
      DROP_CNT   <= '0;
      OVERFLOW   <= 1'b0;
    end else begin
      if (cap) begin
        if (first) begin
          cur_addr  <= RX_ADDR;
          cur_bcast <= RX_BROADCAST;
        end
        cur_len <= do_write ? len_new : len_base;
        discard <= disc_now;
        first   <= !RX_PEND;
      end
      if (fail_start) begin
        first   <= 1'b1;
        discard <= 1'b0;
      end

      // Abandoned partial messages vanish by snapping wr_ptr back to the commit point
      if (fail_start || do_rollback) wr_ptr <= commit_ptr;
      else if (do_write)             wr_ptr <= wr_ptr + 1'b1;

      if (do_commit) begin
        commit_ptr <= wr_ptr + 1'b1;
        hwr_ptr    <= hwr_ptr + 1'b1;
      end
      if (pop)     rd_ptr  <= rd_ptr + 1'b1;
      if (hdr_pop) hrd_ptr <= hrd_ptr + 1'b1;

      if (do_drop && DROP_CNT != 8'hFF) DROP_CNT <= DROP_CNT + 8'd1;
      if (do_rollback)                  OVERFLOW <= 1'b1;
    end
  end

endmodule
